// File: rtl/ariane_pkg.sv
// ---------------------------------------------------------------------------
// ariane_pkg -- shared FU opcode and transaction-tag definitions
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ariane_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [7:0] {
    ADD   = 8'd0,
    MUL   = 8'd1,
    MULH  = 8'd2,
    SMAQA = 8'd3
  } fu_op;

endpackage

`default_nettype wire

// File: rtl/smaqa_dot_sequencer.sv
// ---------------------------------------------------------------------------
// smaqa_dot_sequencer -- chains SMAQA ops on the multiplier into an int8 dot
// product, feeding each tagged result back as the next accumulator.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module smaqa_dot_sequencer
  import ariane_pkg::*;
#(
  parameter int unsigned              LEN_WIDTH = 8,
  parameter logic [TRANS_ID_BITS-1:0] TRANS_ID  = 3'd5
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [31:0]              req_acc_i,
  input  logic [LEN_WIDTH-1:0]     req_len_i,
  input  logic                     op_valid_i,
  output logic                     op_ready_o,
  input  logic [31:0]              op_a_i,
  input  logic [31:0]              op_b_i,
  output logic                     mult_valid_o,
  input  logic                     mult_ready_i,
  output fu_op                     mult_op_o,
  output logic [TRANS_ID_BITS-1:0] mult_trans_id_o,
  output logic [31:0]              mult_operand_a_o,
  output logic [31:0]              mult_operand_b_o,
  output logic [31:0]              mult_operand_c_o,
  input  logic                     mult_valid_i,
  input  logic [TRANS_ID_BITS-1:0] mult_trans_id_i,
  input  logic [31:0]              mult_result_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [31:0]              rsp_data_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_OP  = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_RES = 3'd3,
    S_RESP     = 3'd4
  } dot_seq_state_e;

  localparam logic [LEN_WIDTH-1:0] c_cnt_one = LEN_WIDTH'(1);

  dot_seq_state_e       r_state;
  logic [31:0]          r_acc;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic [31:0]          r_op_a;
  logic [31:0]          r_op_b;
  logic                 r_req_ready;
  logic                 r_op_ready;
  logic                 r_mult_valid;
  logic                 r_rsp_valid;
  logic                 w_res_hit;

  assign w_res_hit = mult_valid_i && (mult_trans_id_i == TRANS_ID);

  // Handshake flags are updated together with the state so every output is a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_req_ready  <= 1'b1;
      r_op_ready   <= 1'b0;
      r_mult_valid <= 1'b0;
      r_rsp_valid  <= 1'b0;
    end else if (flush_i) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_op_ready   <= 1'b0;
      r_mult_valid <= 1'b0;
      r_rsp_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_acc       <= req_acc_i;
            r_cnt       <= req_len_i;
            r_req_ready <= 1'b0;
            if (req_len_i == '0) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state    <= S_WAIT_OP;
              r_op_ready <= 1'b1;
            end
          end
        end
        S_WAIT_OP: begin
          if (op_valid_i) begin
            r_op_a       <= op_a_i;
            r_op_b       <= op_b_i;
            r_op_ready   <= 1'b0;
            r_mult_valid <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mult_ready_i) begin
            r_mult_valid <= 1'b0;
            r_state      <= S_WAIT_RES;
          end
        end
        S_WAIT_RES: begin
          if (w_res_hit) begin
            r_acc <= mult_result_i;
            r_cnt <= r_cnt - c_cnt_one;
            if (r_cnt == c_cnt_one) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state    <= S_WAIT_OP;
              r_op_ready <= 1'b1;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_op_ready   <= 1'b0;
          r_mult_valid <= 1'b0;
          r_rsp_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o      = r_req_ready;
  assign op_ready_o       = r_op_ready;
  assign mult_valid_o     = r_mult_valid;
  assign mult_op_o        = SMAQA;
  assign mult_trans_id_o  = TRANS_ID;
  assign mult_operand_a_o = r_op_a;
  assign mult_operand_b_o = r_op_b;
  assign mult_operand_c_o = r_acc;
  assign rsp_valid_o      = r_rsp_valid;
  assign rsp_data_o       = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_smaqa_dot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_smaqa_dot_sequencer -- directed bench with a single-cycle multiplier model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_smaqa_dot_sequencer;
  import ariane_pkg::*;

  localparam logic [TRANS_ID_BITS-1:0] c_tid = 3'd5;

  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic                     flush_i;
  logic                     req_valid_i;
  logic                     req_ready_o;
  logic [31:0]              req_acc_i;
  logic [7:0]               req_len_i;
  logic                     op_valid_i;
  logic                     op_ready_o;
  logic [31:0]              op_a_i;
  logic [31:0]              op_b_i;
  logic                     mult_valid_o;
  logic                     mult_ready_i;
  fu_op                     mult_op_o;
  logic [TRANS_ID_BITS-1:0] mult_trans_id_o;
  logic [31:0]              mult_operand_a_o;
  logic [31:0]              mult_operand_b_o;
  logic [31:0]              mult_operand_c_o;
  logic                     mult_valid_i;
  logic [TRANS_ID_BITS-1:0] mult_trans_id_i;
  logic [31:0]              mult_result_i;
  logic                     rsp_valid_o;
  logic                     rsp_ready_i;
  logic [31:0]              rsp_data_o;

  smaqa_dot_sequencer dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_acc_i        (req_acc_i),
    .req_len_i        (req_len_i),
    .op_valid_i       (op_valid_i),
    .op_ready_o       (op_ready_o),
    .op_a_i           (op_a_i),
    .op_b_i           (op_b_i),
    .mult_valid_o     (mult_valid_o),
    .mult_ready_i     (mult_ready_i),
    .mult_op_o        (mult_op_o),
    .mult_trans_id_o  (mult_trans_id_o),
    .mult_operand_a_o (mult_operand_a_o),
    .mult_operand_b_o (mult_operand_b_o),
    .mult_operand_c_o (mult_operand_c_o),
    .mult_valid_i     (mult_valid_i),
    .mult_trans_id_i  (mult_trans_id_i),
    .mult_result_i    (mult_result_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_data_o       (rsp_data_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_q[$];

  // Multiplier model state: written only by the model process.
  int                       issues = 0;
  logic [31:0]              issue_log[64];
  logic                     pend = 1'b0;
  logic [31:0]              pend_val = '0;
  logic [TRANS_ID_BITS-1:0] pend_tag = '0;
  logic [31:0]              last_val = '0;
  int                       redo_seen = 0;
  // Model controls: written only by the main process.
  logic                     hold = 1'b0;
  logic [TRANS_ID_BITS-1:0] next_tag = 3'd5;
  int                       redo_cnt = 0;

  function automatic logic [31:0] smaqa(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
    logic [31:0] s;
    int pa, pb;
    s = c;
    for (int i = 0; i < 4; i++) begin
      pa = int'(a[8*i +: 8]);
      pb = int'($signed(b[8*i +: 8]));
      s  = s + 32'(pa * pb);
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Single-cycle multiplier: result appears in the cycle after the issue handshake.
  initial begin
    mult_valid_i    = 1'b0;
    mult_trans_id_i = '0;
    mult_result_i   = '0;
    forever begin
      @(negedge clk_i);
      #1;
      mult_valid_i = 1'b0;
      if (redo_cnt != redo_seen) begin
        redo_seen       = redo_cnt;
        mult_valid_i    = 1'b1;
        mult_trans_id_i = c_tid;
        mult_result_i   = last_val;
      end else if (pend && !hold) begin
        pend            = 1'b0;
        mult_valid_i    = 1'b1;
        mult_trans_id_i = pend_tag;
        mult_result_i   = pend_val;
      end
      if (mult_valid_o && mult_ready_i) begin
        issue_log[issues % 64] = mult_operand_c_o;
        issues   = issues + 1;
        pend     = 1'b1;
        pend_tag = next_tag;
        pend_val = smaqa(mult_operand_a_o, mult_operand_b_o, mult_operand_c_o);
        last_val = pend_val;
      end
    end
  end

  task automatic send_req(input logic [31:0] acc, input logic [7:0] len);
    int k = 0;
    while (req_ready_o !== 1'b1 && k < 100) begin @(negedge clk_i); k++; end
    check("req_ready_timeout", 32'(k < 100), 32'd1);
    req_valid_i = 1'b1; req_acc_i = acc; req_len_i = len;
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic feed_op(input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    while (op_ready_o !== 1'b1 && k < 100) begin @(negedge clk_i); k++; end
    check("op_ready_timeout", 32'(k < 100), 32'd1);
    op_valid_i = 1'b1; op_a_i = a; op_b_i = b;
    @(negedge clk_i);
    op_valid_i = 1'b0;
  endtask

  task automatic get_rsp(input string tag);
    int k = 0;
    logic [31:0] exp;
    while (rsp_valid_o !== 1'b1 && k < 100) begin @(negedge clk_i); k++; end
    check("rsp_valid_timeout", 32'(k < 100), 32'd1);
    exp = 32'hDEAD_BEEF;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    check(tag, rsp_data_o, exp);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    int base;
    rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_acc_i = '0; req_len_i = '0;
    op_valid_i = 1'b0; op_a_i = '0; op_b_i = '0; mult_ready_i = 1'b1; rsp_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);

    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    check("rst_op_ready", 32'(op_ready_o), 32'd0);
    check("rst_mult_valid", 32'(mult_valid_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_mult_op", 32'(mult_op_o), 32'(SMAQA));
    check("rst_trans_id", 32'(mult_trans_id_o), 32'd5);
    check("rst_operand_c", mult_operand_c_o, 32'd0);
    check("rst_rsp_data", rsp_data_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Basic: 10 + 3 * 8
    base = issues;
    exp_q.push_back(32'd34);
    send_req(32'd10, 8'd3);
    repeat (3) feed_op(32'h0101_0101, 32'h0202_0202);
    get_rsp("basic_rsp");
    check("basic_issues", 32'(issues - base), 32'd3);
    check("basic_c0", issue_log[(base + 0) % 64], 32'd10);
    check("basic_c1", issue_log[(base + 1) % 64], 32'd18);
    check("basic_c2", issue_log[(base + 2) % 64], 32'd26);

    // Signed weights
    exp_q.push_back(32'hFFFF_FFF8);
    send_req(32'd0, 8'd2);
    repeat (2) feed_op(32'h0101_0101, 32'hFFFF_FFFF);
    get_rsp("signed_rsp");

    // Zero length: response right after acceptance, nothing issued
    base = issues;
    exp_q.push_back(32'h0000_1234);
    send_req(32'h0000_1234, 8'd0);
    check("zero_rsp_valid", 32'(rsp_valid_o), 32'd1);
    get_rsp("zero_rsp");
    check("zero_issues", 32'(issues - base), 32'd0);

    // Backpressure on issue and on response
    base = issues;
    exp_q.push_back(smaqa(32'h0403_0201, 32'h01FF_02FE,
                    smaqa(32'h0403_0201, 32'h01FF_02FE, 32'd100)));
    send_req(32'd100, 8'd2);
    mult_ready_i = 1'b0;
    feed_op(32'h0403_0201, 32'h01FF_02FE);
    for (int i = 0; i < 4; i++) begin
      check("bp_mult_valid", 32'(mult_valid_o), 32'd1);
      check("bp_operand_a", mult_operand_a_o, 32'h0403_0201);
      check("bp_operand_b", mult_operand_b_o, 32'h01FF_02FE);
      check("bp_operand_c", mult_operand_c_o, 32'd100);
      @(negedge clk_i);
    end
    mult_ready_i = 1'b1;
    feed_op(32'h0403_0201, 32'h01FF_02FE);
    begin
      int k = 0;
      while (rsp_valid_o !== 1'b1 && k < 100) begin @(negedge clk_i); k++; end
      check("bp_rsp_timeout", 32'(k < 100), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
      check("bp_rsp_data", rsp_data_o, 32'd106);
      @(negedge clk_i);
    end
    get_rsp("bp_rsp");
    check("bp_issues", 32'(issues - base), 32'd2);

    // Wrong tag is ignored, then flush while waiting for a result
    send_req(32'd7, 8'd2);
    next_tag = 3'd2;
    feed_op(32'h0101_0101, 32'h0202_0202);
    repeat (4) @(negedge clk_i);
    check("wtag_acc", mult_operand_c_o, 32'd7);
    check("wtag_op_ready", 32'(op_ready_o), 32'd0);
    check("wtag_rsp_valid", 32'(rsp_valid_o), 32'd0);
    next_tag = c_tid;
    redo_cnt = redo_cnt + 1;
    hold = 1'b1;
    feed_op(32'h0101_0101, 32'h0202_0202);
    repeat (2) @(negedge clk_i);
    check("wtag_acc_after", mult_operand_c_o, 32'd15);
    check("flush_pre_op_ready", 32'(op_ready_o), 32'd0);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("flush_req_ready", 32'(req_ready_o), 32'd1);
      check("flush_rsp_valid", 32'(rsp_valid_o), 32'd0);
      @(negedge clk_i);
    end
    check("flush_acc_kept", mult_operand_c_o, 32'd15);

    // Asynchronous reset while issuing
    send_req(32'd1, 8'd1);
    mult_ready_i = 1'b0;
    feed_op(32'h0101_0101, 32'h0101_0101);
    check("arst_pre_mult_valid", 32'(mult_valid_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_mult_valid", 32'(mult_valid_o), 32'd0);
    check("arst_req_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mult_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("arst_no_rsp", 32'(rsp_valid_o), 32'd0);
      check("arst_no_issue", 32'(mult_valid_o), 32'd0);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/smaqa_dot_sequencer.md
Name: smaqa_dot_sequencer

Overview:
- Initiator-side sequencer that drives the multiplier FU interface with a chain of SMAQA operations to compute a full int8 dot product of arbitrary length.
- Accepts a job: initial accumulator plus word count. Consumes one packed operand pair per step (4 lanes of 8 bits each).
- Issues SMAQA with operand_c = running accumulator, collects each result by trans_id and feeds it back as the next accumulator.
- Sits between a load/stream buffer (activation/weight words) and the multiplier; returns the final 32-bit sum on a valid/ready response port.

Parameters:
- LenWidth, 8, width of job length (max 2^LenWidth-1 words).
- TransId, 3'd5, fixed trans_id tag used for every issued op; width TRANS_ID_BITS.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  abort current job, synchronous
- req_valid_i  in  1  job request valid
- req_ready_o  out  1  high only in IDLE
- req_acc_i  in  32  initial accumulator (signed)
- req_len_i  in  LenWidth  number of packed word pairs
- op_valid_i  in  1  operand pair valid
- op_ready_o  out  1  operand pair accepted (high only in WAIT_OP)
- op_a_i  in  32  packed unsigned bytes (rs1 side)
- op_b_i  in  32  packed signed bytes (rs2 side)
- mult_valid_o  out  1  issue to multiplier
- mult_ready_i  in  1  multiplier ready
- mult_op_o  out  fu_op  constant SMAQA
- mult_trans_id_o  out  TRANS_ID_BITS  equals TransId
- mult_operand_a_o / mult_operand_b_o / mult_operand_c_o  out  32 each  captured a, captured b, accumulator
- mult_valid_i  in  1  multiplier result valid
- mult_trans_id_i  in  TRANS_ID_BITS  result tag
- mult_result_i  in  32  SMAQA result
- rsp_valid_o  out  1  final result valid
- rsp_ready_i  in  1  consumer ready
- rsp_data_o  out  32  final accumulator

Behaviour:
- Reset values: state=IDLE; all outputs 0 except req_ready_o=1; mult_op_o=SMAQA; mult_trans_id_o=TransId; acc, remaining count and operand regs cleared.
- FSM states: IDLE, WAIT_OP, ISSUE, WAIT_RES, RESP.
- IDLE: on req_valid_i, latch acc=req_acc_i and cnt=req_len_i. If req_len_i==0, go to RESP (rsp_data_o=req_acc_i). Otherwise go to WAIT_OP.
- WAIT_OP: op_ready_o=1. On op_valid_i, capture op_a_i/op_b_i into registers and go to ISSUE.
- ISSUE: mult_valid_o=1 with the registered operands, operand_c=acc. Hold until mult_ready_i, then go to WAIT_RES. All issued fields are register outputs.
- WAIT_RES: on mult_valid_i && mult_trans_id_i==TransId, set acc<=mult_result_i and cnt<=cnt-1. If cnt==1, go to RESP; else go to WAIT_OP. Results with a mismatched tag are ignored.
- Minimum step period: 3 cycles with single-cycle multiplier latency (WAIT_OP, ISSUE, WAIT_RES).
- RESP: rsp_valid_o=1, rsp_data_o=acc, held stable until rsp_ready_i. Then go to IDLE; req_ready_o rises the next cycle.
- Arithmetic: accumulator is 32-bit two's complement and wraps silently; no saturation or overflow flag.
- flush_i has priority over every transition:
  - next state=IDLE; mult_valid_o/rsp_valid_o drop the next cycle.
  - A result arriving in the cycle after a flush from WAIT_RES is dropped, because the FSM is in IDLE and ignores mult_valid_i.
- Outside WAIT_RES, mult_valid_i is always ignored.
- Reset mid-operation: immediate return to reset values; no response is generated.
- A req_valid_i arriving outside IDLE is not accepted (req_ready_o=0).

Decomposition:
- Shared package ariane_pkg: fu_op (SMAQA), TRANS_ID_BITS. Add a dot_seq_state_e enum there only if reused.
- No sub-module; a single FSM plus datapath registers, roughly 150-200 RTL lines.

Test Plan:
- Basic: acc=10, len=3, each pair a=0x01010101, b=0x02020202, paired with the multiplier model -> rsp_data_o=34 after 3 issues with mult_operand_c_o sequence 10,18,26.
- Signed: acc=0, len=2, a=0x01010101, b=0xFFFFFFFF -> rsp_data_o=0xFFFFFFF8 (-8).
- Zero length: acc=0x1234, len=0 -> rsp_valid_o the cycle after acceptance with 0x1234; mult_valid_o never asserted.
- Backpressure: hold mult_ready_i=0 for 4 cycles and rsp_ready_i=0 for 5 cycles -> operands and rsp_data_o stable, and exactly one issue per step.
- Wrong tag / flush: inject a result with trans_id≠TransId -> acc unchanged. Assert flush_i in WAIT_RES, then deliver the result -> state IDLE, req_ready_o=1, no rsp_valid_o.
- Async reset asserted during ISSUE -> mult_valid_o=0 and req_ready_o=1 immediately.
